// File: rtl/clk_gate_ctrl_if.sv
// Bundle of configuration, per-domain handshake and gate-enable signals for clk_gate_ctrl.
// master drives the controller inputs; slave is the controller itself.
interface clk_gate_ctrl_if #(
    parameter int NUM_DOM = 4,
    parameter int IDLE_W  = 8
);
    logic                cfg_enable;
    logic [IDLE_W-1:0]   idle_thresh;
    logic [NUM_DOM-1:0]  activity;
    logic [NUM_DOM-1:0]  wake_req;
    logic [NUM_DOM-1:0]  sleep_ack;
    logic [NUM_DOM-1:0]  clk_en;
    logic [NUM_DOM-1:0]  sleep_req;
    logic [NUM_DOM-1:0]  dom_ready;
    logic                all_off;

    // sleep_req/sleep_ack form a level handshake: the controller holds sleep_req
    // while in DRAIN and samples sleep_ack only there; activity aborts the request.
    modport master (
        output cfg_enable, idle_thresh, activity, wake_req, sleep_ack,
        input  clk_en, sleep_req, dom_ready, all_off
    );

    modport slave (
        input  cfg_enable, idle_thresh, activity, wake_req, sleep_ack,
        output clk_en, sleep_req, dom_ready, all_off
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gate sequencer: ON -> DRAIN (sleep handshake) -> OFF -> WAKE -> ON.
// All outputs are registered and decoded from the next state so they align with it.
module clk_gate_ctrl #(
    parameter int NUM_DOM  = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 4,
    parameter int WAKE_W   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    clk_gate_ctrl_if.slave         bus,
    output logic [2*NUM_DOM-1:0]   dbg_state
);
    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } dom_state_e;

    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYC - 1);

    logic [NUM_DOM-1:0] on_d;
    logic [NUM_DOM-1:0] drain_d;
    logic [NUM_DOM-1:0] off_d;

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
        dom_state_e        state_q, state_d;
        logic [IDLE_W-1:0] idle_q, idle_d;
        logic [WAKE_W-1:0] wake_q, wake_d;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_ON;
                idle_q  <= '0;
                wake_q  <= '0;
            end else begin
                state_q <= state_d;
                idle_q  <= idle_d;
                wake_q  <= wake_d;
            end
        end

        always_comb begin
            state_d = state_q;
            idle_d  = idle_q;
            wake_d  = wake_q;
            case (state_q)
                ST_ON: begin
                    if (bus.activity[g])
                        idle_d = '0;
                    else if (idle_q != '1)
                        idle_d = idle_q + IDLE_ONE;
                    // Equality (not >=) so a lowered threshold waits for activity to clear the count.
                    if (bus.cfg_enable && (bus.idle_thresh != '0) && !bus.activity[g] &&
                        (idle_q == bus.idle_thresh - IDLE_ONE))
                        state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.activity[g] || !bus.cfg_enable) begin
                        state_d = ST_ON;
                        idle_d  = '0;
                    end else if (bus.sleep_ack[g]) begin
                        state_d = ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (bus.activity[g] || bus.wake_req[g] || !bus.cfg_enable) begin
                        state_d = ST_WAKE;
                        wake_d  = WAKE_LOAD;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == '0) begin
                        state_d = ST_ON;
                        idle_d  = '0;
                    end else begin
                        wake_d = wake_q - WAKE_ONE;
                    end
                end
                default: state_d = ST_ON;
            endcase
        end

        assign on_d[g]    = (state_d == ST_ON);
        assign drain_d[g] = (state_d == ST_DRAIN);
        assign off_d[g]   = (state_d == ST_OFF);
        assign dbg_state[2*g +: 2] = state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.clk_en    <= '1;
            bus.sleep_req <= '0;
            bus.dom_ready <= '1;
            bus.all_off   <= 1'b0;
        end else begin
            bus.clk_en    <= ~off_d;
            bus.sleep_req <= drain_d;
            bus.dom_ready <= on_d;
            bus.all_off   <= &off_d;
        end
    end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: expected output vectors are queued as stimulus is
// applied and compared one cycle later against {clk_en, sleep_req, dom_ready, all_off}.
module tb_clk_gate_ctrl;
    localparam int NUM_DOM  = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 4;
    localparam int WAKE_W   = 4;
    localparam int W        = 3*NUM_DOM + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [2*NUM_DOM-1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    clk_gate_ctrl_if #(.NUM_DOM(NUM_DOM), .IDLE_W(IDLE_W)) bus ();

    clk_gate_ctrl #(
        .NUM_DOM(NUM_DOM), .IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC), .WAKE_W(WAKE_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pk(input logic [3:0] ce, input logic [3:0] sr,
                                        input logic [3:0] dr, input logic ao);
        return {ce, sr, dr, ao};
    endfunction

    task automatic compare(input string tag);
        logic [W-1:0] obs;
        logic [W-1:0] e;
        obs = {bus.clk_en, bus.sleep_req, bus.dom_ready, bus.all_off};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic edge_check(input string tag, input logic [W-1:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic now_check(input string tag, input logic [W-1:0] e);
        exp_q.push_back(e);
        compare(tag);
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.cfg_enable  = 1'b1;
        bus.idle_thresh = '0;
        bus.activity    = 4'hF;
        bus.wake_req    = '0;
        bus.sleep_ack   = '0;
        repeat (3) @(posedge clk);
        #1;
        now_check("reset_state", pk(4'hF, 4'h0, 4'hF, 1'b0));
        reset_n = 1'b1;

        // Domain 0 idles with threshold 3, then acknowledges sleep.
        bus.activity    = 4'b1110;
        bus.idle_thresh = 8'd3;
        edge_check("d0_idle1", pk(4'hF, 4'h0, 4'hF, 1'b0));
        edge_check("d0_idle2", pk(4'hF, 4'h0, 4'hF, 1'b0));
        edge_check("d0_drain", pk(4'hF, 4'b0001, 4'b1110, 1'b0));
        bus.sleep_ack = 4'b0001;
        edge_check("d0_off", pk(4'b1110, 4'h0, 4'b1110, 1'b0));
        bus.sleep_ack = '0;

        // Domain 1 drains, then activity and sleep_ack arrive together: abort wins.
        bus.activity = 4'b1100;
        edge_check("d1_idle1", pk(4'b1110, 4'h0, 4'b1110, 1'b0));
        edge_check("d1_idle2", pk(4'b1110, 4'h0, 4'b1110, 1'b0));
        edge_check("d1_drain", pk(4'b1110, 4'b0010, 4'b1100, 1'b0));
        bus.activity  = 4'b1110;
        bus.sleep_ack = 4'b0010;
        edge_check("d1_abort", pk(4'b1110, 4'h0, 4'b1110, 1'b0));
        bus.sleep_ack = '0;
        edge_check("d1_stay_on", pk(4'b1110, 4'h0, 4'b1110, 1'b0));

        // Domain 2 gates off, then a one-cycle wake_req; activity toggles in WAKE are ignored.
        bus.activity = 4'b1010;
        edge_check("d2_idle1", pk(4'b1110, 4'h0, 4'b1110, 1'b0));
        edge_check("d2_idle2", pk(4'b1110, 4'h0, 4'b1110, 1'b0));
        edge_check("d2_drain", pk(4'b1110, 4'b0100, 4'b1010, 1'b0));
        bus.sleep_ack = 4'b0100;
        edge_check("d2_off", pk(4'b1010, 4'h0, 4'b1010, 1'b0));
        bus.sleep_ack = '0;
        bus.wake_req  = 4'b0100;
        edge_check("d2_wake_clk_en", pk(4'b1110, 4'h0, 4'b1010, 1'b0));
        bus.wake_req = '0;
        bus.activity = 4'b1110;
        edge_check("d2_wake1", pk(4'b1110, 4'h0, 4'b1010, 1'b0));
        bus.activity = 4'b1010;
        edge_check("d2_wake2", pk(4'b1110, 4'h0, 4'b1010, 1'b0));
        bus.activity = 4'b1110;
        edge_check("d2_wake3", pk(4'b1110, 4'h0, 4'b1010, 1'b0));
        edge_check("d2_ready", pk(4'b1110, 4'h0, 4'b1110, 1'b0));

        // Bring domain 0 back so every domain is ON.
        bus.wake_req = 4'b0001;
        edge_check("d0_wake0", pk(4'hF, 4'h0, 4'b1110, 1'b0));
        bus.wake_req = '0;
        for (int i = 0; i < WAKE_CYC - 1; i++)
            edge_check("d0_waking", pk(4'hF, 4'h0, 4'b1110, 1'b0));
        edge_check("d0_ready", pk(4'hF, 4'h0, 4'hF, 1'b0));

        // Threshold 0 never gates; idle counters saturate meanwhile.
        bus.idle_thresh = '0;
        bus.activity    = '0;
        for (int i = 0; i < 300; i++)
            edge_check("thresh_zero", pk(4'hF, 4'h0, 4'hF, 1'b0));
        bus.idle_thresh = 8'd1;
        edge_check("lowered_thresh1", pk(4'hF, 4'h0, 4'hF, 1'b0));
        edge_check("lowered_thresh2", pk(4'hF, 4'h0, 4'hF, 1'b0));
        bus.activity = 4'hF;
        edge_check("count_clear", pk(4'hF, 4'h0, 4'hF, 1'b0));
        bus.activity = '0;
        edge_check("thresh_one_drain", pk(4'hF, 4'hF, 4'h0, 1'b0));

        // Everything off, then cfg_enable drops and wakes all domains.
        bus.sleep_ack = 4'hF;
        edge_check("all_off", pk(4'h0, 4'h0, 4'h0, 1'b1));
        bus.sleep_ack = '0;
        edge_check("all_off_hold", pk(4'h0, 4'h0, 4'h0, 1'b1));
        bus.cfg_enable = 1'b0;
        edge_check("cfg_wake0", pk(4'hF, 4'h0, 4'h0, 1'b0));
        for (int i = 0; i < WAKE_CYC - 1; i++)
            edge_check("cfg_waking", pk(4'hF, 4'h0, 4'h0, 1'b0));
        edge_check("cfg_ready", pk(4'hF, 4'h0, 4'hF, 1'b0));
        for (int i = 0; i < 10; i++)
            edge_check("cfg_no_regate", pk(4'hF, 4'h0, 4'hF, 1'b0));

        // Async reset with domain 0 OFF and domain 1 in DRAIN.
        bus.cfg_enable  = 1'b1;
        bus.idle_thresh = 8'd3;
        bus.activity    = 4'hF;
        edge_check("pre_rst_clear", pk(4'hF, 4'h0, 4'hF, 1'b0));
        bus.activity = 4'b1100;
        edge_check("pre_rst_idle1", pk(4'hF, 4'h0, 4'hF, 1'b0));
        edge_check("pre_rst_idle2", pk(4'hF, 4'h0, 4'hF, 1'b0));
        edge_check("pre_rst_drain", pk(4'hF, 4'b0011, 4'b1100, 1'b0));
        bus.sleep_ack = 4'b0001;
        edge_check("pre_rst_d0_off", pk(4'b1110, 4'b0010, 4'b1100, 1'b0));
        bus.sleep_ack = 4'b0000;
        #3;
        reset_n = 1'b0;
        #1;
        now_check("async_reset", pk(4'hF, 4'h0, 4'hF, 1'b0));
        @(posedge clk);
        #1;
        now_check("held_reset", pk(4'hF, 4'h0, 4'hF, 1'b0));
        reset_n = 1'b1;
        edge_check("post_rst_idle1", pk(4'hF, 4'h0, 4'hF, 1'b0));
        edge_check("post_rst_idle2", pk(4'hF, 4'h0, 4'hF, 1'b0));
        edge_check("post_rst_drain", pk(4'hF, 4'b0011, 4'b1100, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
